// File: rtl/rank_decider.sv
// Rank decider: collects one mismatch score per rank template, scans them serially
// for best and second-best, and reports the winning rank with confidence/timeout flags.
module rank_decider #(
  parameter int NUM_RANKS     = 13,
  parameter int SCORE_W       = 11,
  parameter int REJECT_THRESH = 400,
  parameter int MARGIN        = 40,
  parameter int TIMEOUT       = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic [NUM_RANKS*SCORE_W-1:0]   scores,
  input  logic [NUM_RANKS-1:0]           score_valid,
  output logic [3:0]                     rank_id,
  output logic [SCORE_W-1:0]             best_score,
  output logic [SCORE_W-1:0]             second_score,
  output logic                           rank_valid,
  output logic                           rank_reject,
  output logic                           rank_timeout,
  output logic                           busy,
  output logic                           overrun
);

  localparam int IDX_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {COLLECT = 2'd0, COMPARE = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [NUM_RANKS-1:0]   seen_q, seen_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SCORE_W-1:0]     scan_best_q, scan_best_d;
  logic [SCORE_W-1:0]     scan_second_q, scan_second_d;
  logic [IDX_W-1:0]       scan_id_q, scan_id_d;
  logic                   pend_q, pend_d;
  logic                   overrun_q, overrun_d;
  logic [3:0]             rank_id_q, rank_id_d;
  logic [SCORE_W-1:0]     best_q, best_d;
  logic [SCORE_W-1:0]     second_q, second_d;
  logic                   valid_q, valid_d;
  logic                   reject_q, reject_d;
  logic                   timeout_q, timeout_d;
  logic [SCORE_W-1:0]     slot_q [NUM_RANKS];

  logic [NUM_RANKS-1:0]   seen_upd;
  logic [SCORE_W-1:0]     cur_score;
  logic [SCORE_W-1:0]     gap;
  logic                   any_valid;
  logic                   low_conf;

  // Slots are only written while collecting; scores arriving while busy are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RANKS; i++) begin
      if (state_q == COLLECT && score_valid[i]) begin
        slot_q[i] <= scores[i*SCORE_W +: SCORE_W];
      end
    end
  end

  assign any_valid = |score_valid;
  assign seen_upd  = frame_start ? score_valid : (seen_q | score_valid);
  assign cur_score = slot_q[idx_q];
  assign gap       = scan_second_q - scan_best_q;
  assign low_conf  = (32'(scan_best_q) > REJECT_THRESH) || (32'(gap) < MARGIN);

  always_comb begin
    state_d       = state_q;
    seen_d        = seen_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    scan_best_d   = scan_best_q;
    scan_second_d = scan_second_q;
    scan_id_d     = scan_id_q;
    pend_d        = pend_q;
    overrun_d     = overrun_q;
    rank_id_d     = rank_id_q;
    best_d        = best_q;
    second_d      = second_q;
    valid_d       = 1'b0;
    reject_d      = reject_q;
    timeout_d     = timeout_q;

    case (state_q)
      COLLECT: begin
        seen_d = seen_upd;
        if (frame_start) begin
          overrun_d = 1'b0;
          cnt_d     = '0;
        end else if (|seen_q) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (&seen_upd) begin
          state_d       = COMPARE;
          idx_d         = '0;
          scan_best_d   = '1;
          scan_second_d = '1;
          scan_id_d     = '1;
          cnt_d         = '0;
        end else if (!frame_start && (|seen_q) && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          reject_d  = 1'b1;
          rank_id_d = 4'hF;
          best_d    = '1;
          second_d  = '1;
          seen_d    = '0;
          cnt_d     = '0;
        end
      end
      COMPARE: begin
        overrun_d = overrun_q | any_valid;
        if (frame_start) pend_d = 1'b1;
        // Strict compares: on a tie the earlier index keeps best, the equal value becomes second.
        if (cur_score < scan_best_q) begin
          scan_second_d = scan_best_q;
          scan_best_d   = cur_score;
          scan_id_d     = idx_q;
        end else if (cur_score < scan_second_q) begin
          scan_second_d = cur_score;
        end
        if (idx_q == IDX_W'(NUM_RANKS - 1)) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        valid_d   = 1'b1;
        rank_id_d = 4'(scan_id_q);
        best_d    = scan_best_q;
        second_d  = scan_second_q;
        reject_d  = low_conf;
        timeout_d = 1'b0;
        state_d   = COLLECT;
        seen_d    = '0;
        cnt_d     = '0;
        pend_d    = 1'b0;
        overrun_d = (pend_q || frame_start) ? 1'b0 : (overrun_q | any_valid);
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= COLLECT;
      seen_q        <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      scan_best_q   <= '1;
      scan_second_q <= '1;
      scan_id_q     <= '1;
      pend_q        <= 1'b0;
      overrun_q     <= 1'b0;
      rank_id_q     <= 4'hF;
      best_q        <= '1;
      second_q      <= '1;
      valid_q       <= 1'b0;
      reject_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      seen_q        <= seen_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      scan_best_q   <= scan_best_d;
      scan_second_q <= scan_second_d;
      scan_id_q     <= scan_id_d;
      pend_q        <= pend_d;
      overrun_q     <= overrun_d;
      rank_id_q     <= rank_id_d;
      best_q        <= best_d;
      second_q      <= second_d;
      valid_q       <= valid_d;
      reject_q      <= reject_d;
      timeout_q     <= timeout_d;
    end
  end

  assign rank_id      = rank_id_q;
  assign best_score   = best_q;
  assign second_score = second_q;
  assign rank_valid   = valid_q;
  assign rank_reject  = reject_q;
  assign rank_timeout = timeout_q;
  assign busy         = (state_q != COLLECT);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_rank_decider.sv
// Self-checking bench for rank_decider: directed frames, randomized frames with
// overwrites, timeout, frame_start abort, overrun and mid-scan reset.
module tb_rank_decider;
  localparam int N  = 13;
  localparam int W  = 11;
  localparam int RT = 400;
  localparam int MG = 40;
  localparam int TO = 4096;
  localparam int LAT = N + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_start = 1'b0;
  logic [N*W-1:0] scores = '0;
  logic [N-1:0]   score_valid = '0;
  logic [3:0]     rank_id;
  logic [W-1:0]   best_score, second_score;
  logic           rank_valid, rank_reject, rank_timeout, busy, overrun;

  rank_decider #(.NUM_RANKS(N), .SCORE_W(W), .REJECT_THRESH(RT), .MARGIN(MG), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .scores(scores), .score_valid(score_valid),
    .rank_id(rank_id), .best_score(best_score), .second_score(second_score),
    .rank_valid(rank_valid), .rank_reject(rank_reject), .rank_timeout(rank_timeout),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int sc [N];
  int exp_id, exp_best, exp_second;
  bit exp_rej, exp_to;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sort all frame scores; lowest index holding the minimum wins.
  task automatic model();
    int q[$];
    q = {};
    for (int i = 0; i < N; i++) q.push_back(sc[i]);
    q.sort();
    exp_best   = q[0];
    exp_second = q[1];
    exp_id     = -1;
    for (int i = 0; i < N; i++) if (exp_id < 0 && sc[i] == exp_best) exp_id = i;
    exp_rej = (exp_best > RT) || ((exp_second - exp_best) < MG);
    exp_to  = 1'b0;
  endtask

  function automatic logic [N*W-1:0] pack();
    logic [N*W-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = W'(sc[i]);
    return p;
  endfunction

  function automatic logic [27:0] got_vec();
    return {rank_id, best_score, second_score, rank_reject, rank_timeout};
  endfunction

  function automatic logic [27:0] exp_vec();
    return {4'(exp_id), W'(exp_best), W'(exp_second), exp_rej, exp_to};
  endfunction

  task automatic show_fail(input string name);
    $display("FAIL %s: got id=%0d best=%0d sec=%0d rej=%0b to=%0b, expected id=%0d best=%0d sec=%0d rej=%0b to=%0b",
             name, rank_id, best_score, second_score, rank_reject, rank_timeout,
             exp_id, exp_best, exp_second, exp_rej, exp_to);
  endtask

  task automatic drive(input logic [N-1:0] m, input bit fs);
    scores      = pack();
    score_valid = m;
    frame_start = fs;
    tick();
    score_valid = '0;
    frame_start = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (rank_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    exp_id = 15; exp_best = 2047; exp_second = 2047; exp_rej = 0; exp_to = 0;
    checks++;
    if (got_vec() !== exp_vec()) begin failures++; show_fail("reset_outputs"); end
    checks++;
    if ({rank_valid, busy, overrun} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got valid/busy/overrun=%b expected 000", {rank_valid, busy, overrun});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({rank_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release: got valid/busy=%b expected 00", {rank_valid, busy});
    end
    $display("reset done");
  endtask

  task automatic test_directed();
    int n;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) begin
        case (c)
          0: sc[i] = (i == 9) ? 35 : 500 - 10 * i;
          1: sc[i] = (i == 3 || i == 7) ? 50 : 600;
          default: sc[i] = 450;
        endcase
      end
      model();
      drive('1, 1'b0);
      wait_valid(LAT + 50, n);
      checks++;
      if (rank_valid !== 1'b1 || n != LAT) begin
        failures++;
        $display("FAIL directed%0d_latency: got %0d cycles valid=%b expected %0d", c, n, rank_valid, LAT);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin failures++; show_fail($sformatf("directed%0d_result", c)); end
      $display("frame directed%0d id=%0d best=%0d second=%0d rej=%0b lat=%0d",
               c, rank_id, best_score, second_score, rank_reject, n);
      tick();
      checks++;
      if (rank_valid !== 1'b0 || got_vec() !== exp_vec()) begin
        failures++;
        show_fail($sformatf("directed%0d_hold", c));
      end
    end
  endtask

  task automatic test_random();
    int n, cyc;
    bit narrow;
    logic [N-1:0] seen, m;
    for (int f = 0; f < 25; f++) begin
      narrow = ($urandom_range(0, 1) == 1);
      seen = '0;
      cyc = 0;
      while (seen != '1) begin
        m = (cyc >= 30) ? ~seen : N'($urandom & $urandom);
        for (int i = 0; i < N; i++)
          if (m[i]) sc[i] = narrow ? $urandom_range(0, 60) : $urandom_range(0, 2047);
        drive(m, 1'b0);
        seen |= m;
        cyc++;
      end
      model();
      wait_valid(LAT + 50, n);
      checks++;
      if (rank_valid !== 1'b1 || n != LAT) begin
        failures++;
        $display("FAIL random%0d_latency: got %0d cycles valid=%b expected %0d", f, n, rank_valid, LAT);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin failures++; show_fail($sformatf("random%0d_result", f)); end
      $display("frame random%0d id=%0d best=%0d second=%0d rej=%0b lat=%0d",
               f, rank_id, best_score, second_score, rank_reject, n);
    end
  endtask

  task automatic test_timeout();
    int n;
    for (int i = 0; i < N; i++) sc[i] = 100 + i;
    drive(N'(13'h0FFF), 1'b0);
    wait_valid(TO + 100, n);
    exp_id = 15; exp_best = 2047; exp_second = 2047; exp_rej = 1; exp_to = 1;
    checks++;
    if (rank_valid !== 1'b1 || n != TO) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles valid=%b expected %0d", n, rank_valid, TO);
    end
    checks++;
    if (got_vec() !== exp_vec()) begin failures++; show_fail("timeout_result"); end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy: got %b expected 0", busy);
    end
    $display("frame timeout id=%0d to=%0b lat=%0d", rank_id, rank_timeout, n);
  endtask

  task automatic test_frame_start_abort();
    int n;
    for (int i = 0; i < N; i++) sc[i] = 5 + i;
    drive(N'(13'h0FFF), 1'b0);
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(200, 1500);
    drive(N'(13'h1000), 1'b1);
    drive(N'(13'h0FFF), 1'b0);
    model();
    wait_valid(LAT + 50, n);
    checks++;
    if (rank_valid !== 1'b1 || n != LAT) begin
      failures++;
      $display("FAIL abort_latency: got %0d cycles valid=%b expected %0d", n, rank_valid, LAT);
    end
    checks++;
    if (got_vec() !== exp_vec()) begin failures++; show_fail("abort_result"); end
    $display("frame abort id=%0d best=%0d second=%0d lat=%0d", rank_id, best_score, second_score, n);
  endtask

  task automatic test_overrun();
    int n, saved;
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(100, 2000);
    model();
    drive('1, 1'b0);
    tick(); tick(); tick();
    saved = sc[0];
    sc[0] = 0;
    drive(N'(1), 1'b0);
    sc[0] = saved;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    wait_valid(LAT + 50, n);
    checks++;
    if (rank_valid !== 1'b1 || n + 4 != LAT) begin
      failures++;
      $display("FAIL overrun_latency: got %0d cycles valid=%b expected %0d", n + 4, rank_valid, LAT);
    end
    checks++;
    if (got_vec() !== exp_vec()) begin failures++; show_fail("overrun_result"); end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
    $display("frame overrun id=%0d best=%0d second=%0d lat=%0d", rank_id, best_score, second_score, n + 4);
    drive('0, 1'b1);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: got %b expected 0", overrun);
    end

    for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 700);
    model();
    drive('1, 1'b0);
    tick();
    drive(N'(2), 1'b1);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_fs_overrun: got overrun=%b busy=%b expected 1 1", overrun, busy);
    end
    wait_valid(LAT + 50, n);
    checks++;
    if (rank_valid !== 1'b1 || n + 2 != LAT || got_vec() !== exp_vec()) begin
      failures++;
      show_fail($sformatf("busy_fs_result lat=%0d", n + 2));
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL busy_fs_clear: got %b expected 0", overrun);
    end
    $display("frame busy_fs id=%0d best=%0d second=%0d lat=%0d", rank_id, best_score, second_score, n + 2);
  endtask

  task automatic test_reset_mid_compare();
    int n, seen_valid;
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 300);
    drive('1, 1'b0);
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_id = 15; exp_best = 2047; exp_second = 2047; exp_rej = 0; exp_to = 0;
    checks++;
    if (got_vec() !== exp_vec() || {rank_valid, busy, overrun} !== 3'b000) begin
      failures++;
      show_fail($sformatf("midreset_outputs flags=%b", {rank_valid, busy, overrun}));
    end
    seen_valid = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rank_valid === 1'b1) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin
      failures++;
      $display("FAIL midreset_no_valid: got %0d strobes expected 0", seen_valid);
    end
    for (int i = 0; i < N; i++) sc[i] = $urandom_range(0, 2047);
    model();
    drive('1, 1'b0);
    wait_valid(LAT + 50, n);
    checks++;
    if (rank_valid !== 1'b1 || n != LAT || got_vec() !== exp_vec()) begin
      failures++;
      show_fail($sformatf("midreset_next_frame lat=%0d", n));
    end
    $display("frame after_reset id=%0d best=%0d second=%0d lat=%0d", rank_id, best_score, second_score, n);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_frame_start_abort();
    test_overrun();
    test_reset_mid_compare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
